// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-port register file.
// NREGS-1 general registers plus a dedicated PC at the top index.
// It has two write ports (A: ALU result via sel_rd; B: base-register writeback),
// three combinational read ports, PC load/increment logic, and a registered
// write-collision flag.
// Optional feature: define RF_BYPASS_EN to forward same-cycle write data onto the read ports.
module reg_file_mp #(
    parameter int              WIDTH    = 32,
    parameter int              ADDR_W   = 4,
    parameter int              PC_STEP  = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic              Clk,
    input  logic              RESET,
    input  logic              IR_CU,
    input  logic [ADDR_W-1:0] ir_rn,
    input  logic [ADDR_W-1:0] ir_rm,
    input  logic [ADDR_W-1:0] ir_rs,
    input  logic [ADDR_W-1:0] ir_rd,
    input  logic [ADDR_W-1:0] cu_rn,
    input  logic [ADDR_W-1:0] cu_rm,
    input  logic [ADDR_W-1:0] cu_rs,
    input  logic [ADDR_W-1:0] cu_rd,
    input  logic [WIDTH-1:0]  in,
    input  logic              LOAD,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [WIDTH-1:0]  wb_data,
    input  logic              wb_we,
    input  logic [WIDTH-1:0]  Pcin,
    input  logic              LOADPC,
    input  logic              PC_INC,
    output logic [WIDTH-1:0]  Rn,
    output logic [WIDTH-1:0]  Rm,
    output logic [WIDTH-1:0]  Rs,
    output logic [WIDTH-1:0]  PCout,
    output logic              wr_conflict
);

    localparam int                NREGS  = 2 ** ADDR_W;
    localparam int                PC_IDX = NREGS - 1;
    localparam logic [ADDR_W-1:0] PC_SEL = ADDR_W'(PC_IDX);

    // Register storage: general registers 0..NREGS-2, PC kept separately.
    logic [WIDTH-1:0] gpr [NREGS-1];
    logic [WIDTH-1:0] pc;

    // Selected addresses after the IR/CU mux.
    logic [ADDR_W-1:0] sel_rn, sel_rm, sel_rs, sel_rd;

    // Next-state view of every index (PC at PC_IDX) and what the read ports see.
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] nxt_view  [NREGS];
    logic [WIDTH-1:0] read_view [NREGS];

    // Select mux: the instruction register or the control unit drives the selects.
    always_comb begin
        sel_rn = IR_CU ? ir_rn : cu_rn;
        sel_rm = IR_CU ? ir_rm : cu_rm;
        sel_rs = IR_CU ? ir_rs : cu_rs;
        sel_rd = IR_CU ? ir_rd : cu_rd;
    end

    // PC next value: load beats port A, which beats port B, which beats increment.
    always_comb begin
        pc_next = pc;
        if (LOADPC)
            pc_next = Pcin;
        else if (LOAD && (sel_rd == PC_SEL))
            pc_next = in;
        else if (wb_we && (wb_addr == PC_SEL))
            pc_next = wb_data;
        else if (PC_INC)
            pc_next = pc + WIDTH'(PC_STEP);
    end

    // General register next values: port A wins over port B on the same index.
    always_comb begin
        for (int i = 0; i < PC_IDX; i++) begin
            nxt_view[i] = gpr[i];
            if (LOAD && (sel_rd == ADDR_W'(i)))
                nxt_view[i] = in;
            else if (wb_we && (wb_addr == ADDR_W'(i)))
                nxt_view[i] = wb_data;
        end
        nxt_view[PC_IDX] = pc_next;
    end

`ifdef RF_BYPASS_EN
    // Read view forwards the values about to be written this cycle.
    always_comb begin
        for (int i = 0; i < NREGS; i++)
            read_view[i] = nxt_view[i];
    end
`else
    // Read view is the stored (pre-edge) contents; write-then-read takes a cycle.
    always_comb begin
        for (int i = 0; i < PC_IDX; i++)
            read_view[i] = gpr[i];
        read_view[PC_IDX] = pc;
    end
`endif

    // Read ports: zero-latency index into the read view.
    always_comb begin
        Rn    = read_view[sel_rn];
        Rm    = read_view[sel_rm];
        Rs    = read_view[sel_rs];
        PCout = pc;
    end

    // State update. Async reset clears everything and blocks the coincident edge.
    always_ff @(posedge Clk or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < PC_IDX; i++)
                gpr[i] <= '0;
            pc          <= RESET_PC;
            wr_conflict <= 1'b0;
        end else begin
            for (int i = 0; i < PC_IDX; i++)
                gpr[i] <= nxt_view[i];
            pc          <= pc_next;
            wr_conflict <= LOAD && wb_we && (sel_rd == wb_addr);
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed bench for reg_file_mp (default parameters).
// Expected values go into exp_q when a step is driven and are popped when the DUT output is sampled.
module tb_reg_file_mp;

    localparam int W = 32;
    localparam int A = 4;

    logic         Clk, RESET, IR_CU;
    logic [A-1:0] ir_rn, ir_rm, ir_rs, ir_rd;
    logic [A-1:0] cu_rn, cu_rm, cu_rs, cu_rd;
    logic [W-1:0] in, wb_data, Pcin;
    logic [A-1:0] wb_addr;
    logic         LOAD, wb_we, LOADPC, PC_INC;
    logic [W-1:0] Rn, Rm, Rs, PCout;
    logic         wr_conflict;

    logic [W-1:0] exp_q[$];
    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] tmp;

    reg_file_mp dut (
        .Clk(Clk), .RESET(RESET), .IR_CU(IR_CU),
        .ir_rn(ir_rn), .ir_rm(ir_rm), .ir_rs(ir_rs), .ir_rd(ir_rd),
        .cu_rn(cu_rn), .cu_rm(cu_rm), .cu_rs(cu_rs), .cu_rd(cu_rd),
        .in(in), .LOAD(LOAD), .wb_addr(wb_addr), .wb_data(wb_data), .wb_we(wb_we),
        .Pcin(Pcin), .LOADPC(LOADPC), .PC_INC(PC_INC),
        .Rn(Rn), .Rm(Rm), .Rs(Rs), .PCout(PCout), .wr_conflict(wr_conflict)
    );

    // Clock: 10 time-unit period.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Deassert every enable.
    task automatic idle();
        LOAD = 1'b0; wb_we = 1'b0; LOADPC = 1'b0; PC_INC = 1'b0;
    endtask

    // Scoreboard push.
    task automatic expect_val(input logic [W-1:0] v);
        exp_q.push_back(v);
    endtask

    // Scoreboard pop and compare.
    task automatic check_val(input string tag, input logic [W-1:0] obs);
        logic [W-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed=%h expected=<empty queue>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    // Write a general register through port A using the IR selects.
    task automatic write_a(input logic [A-1:0] rd, input logic [W-1:0] d);
        IR_CU = 1'b1; ir_rd = rd; in = d; LOAD = 1'b1;
        tick();
        LOAD = 1'b0;
    endtask

    // Read a register through Rn using the IR selects.
    task automatic read_rn(input logic [A-1:0] idx, output logic [W-1:0] v);
        IR_CU = 1'b1; ir_rn = idx;
        #1;
        v = Rn;
    endtask

    initial begin
        RESET = 1'b0; IR_CU = 1'b1;
        ir_rn = '0; ir_rm = '0; ir_rs = '0; ir_rd = '0;
        cu_rn = '0; cu_rm = '0; cu_rs = '0; cu_rd = '0;
        in = '0; wb_addr = '0; wb_data = '0; Pcin = '0;
        idle();
        @(negedge Clk);
        @(negedge Clk);
        RESET = 1'b1;

        // Reset state.
        read_rn(4'd3, tmp);
        expect_val(32'h0); check_val("reset_r3", tmp);
        expect_val(32'h0); check_val("reset_pc", PCout);
        expect_val(32'h0); check_val("reset_conflict", {31'b0, wr_conflict});

        // Reset and hold: write R3, load PC, then async reset mid-cycle.
        IR_CU = 1'b1; ir_rd = 4'd3; in = 32'h55; LOAD = 1'b1;
        LOADPC = 1'b1; Pcin = 32'h40;
        tick();
        idle();
        read_rn(4'd3, tmp);
        expect_val(32'h55); check_val("r3_written", tmp);
        expect_val(32'h40); check_val("pc_loaded", PCout);
        #2;
        RESET = 1'b0;
        #1;
        expect_val(32'h0); check_val("async_reset_r3", Rn);
        expect_val(32'h0); check_val("async_reset_pc", PCout);
        ir_rd = 4'd3; in = 32'h7; LOAD = 1'b1;
        tick();
        expect_val(32'h0); check_val("write_blocked_in_reset", Rn);
        idle();
        #2;
        RESET = 1'b1;

        // Chained increment via R0..R2, Rn result fed back into in.
        write_a(4'd0, 32'h1);
        read_rn(4'd0, tmp);
        write_a(4'd1, tmp + 32'h1);
        read_rn(4'd1, tmp);
        write_a(4'd2, tmp + 32'h1);
        IR_CU = 1'b1; ir_rn = 4'd0; ir_rm = 4'd1; ir_rs = 4'd2;
        #1;
        expect_val(32'h1); check_val("chain_rn", Rn);
        expect_val(32'h2); check_val("chain_rm", Rm);
        expect_val(32'h3); check_val("chain_rs", Rs);

        // IR_CU select mux on a read path.
        write_a(4'd1, 32'hA);
        write_a(4'd2, 32'hB);
        ir_rn = 4'd1; cu_rn = 4'd2; IR_CU = 1'b1;
        #1;
        expect_val(32'hA); check_val("mux_rn_ir", Rn);
        IR_CU = 1'b0;
        #1;
        expect_val(32'hB); check_val("mux_rn_cu", Rn);

        // IR_CU select mux on the rd path.
        IR_CU = 1'b1; ir_rd = 4'd8; cu_rd = 4'd9; in = 32'h81; LOAD = 1'b1;
        tick();
        IR_CU = 1'b0; cu_rd = 4'd9; ir_rd = 4'd8; in = 32'h91;
        read_rn(4'd9, tmp);
        expect_val(32'h0); check_val("mux_rd_ir_not_cu", tmp);
        IR_CU = 1'b0;
        tick();
        LOAD = 1'b0;
        read_rn(4'd8, tmp);
        expect_val(32'h81); check_val("mux_rd_ir", tmp);
        read_rn(4'd9, tmp);
        expect_val(32'h91); check_val("mux_rd_cu", tmp);

        // Dual write, distinct indices: both land, no conflict.
        IR_CU = 1'b1; ir_rd = 4'd4; in = 32'h11; LOAD = 1'b1;
        wb_addr = 4'd5; wb_data = 32'h22; wb_we = 1'b1;
        tick();
        expect_val(32'h0); check_val("no_conflict", {31'b0, wr_conflict});
        // Same index: port A wins, conflict pulses.
        ir_rd = 4'd6; in = 32'h33; wb_addr = 4'd6; wb_data = 32'h44;
        tick();
        expect_val(32'h1); check_val("conflict_set", {31'b0, wr_conflict});
        idle();
        in = 'x; wb_data = 'x;
        read_rn(4'd4, tmp);
        expect_val(32'h11); check_val("dual_r4", tmp);
        read_rn(4'd5, tmp);
        expect_val(32'h22); check_val("dual_r5", tmp);
        read_rn(4'd6, tmp);
        expect_val(32'h33); check_val("collide_r6", tmp);
        tick();
        expect_val(32'h0); check_val("conflict_cleared", {31'b0, wr_conflict});
        read_rn(4'd4, tmp);
        expect_val(32'h11); check_val("disabled_x_data_r4", tmp);
        in = '0; wb_data = '0;

        // PC increment from reset value.
        PC_INC = 1'b1;
        tick(); tick(); tick();
        PC_INC = 1'b0;
        expect_val(32'd12); check_val("pc_inc3", PCout);
        read_rn(4'd15, tmp);
        expect_val(32'd12); check_val("pc_via_rn", tmp);

        // LOADPC beats port A and increment.
        LOADPC = 1'b1; Pcin = 32'h100; PC_INC = 1'b1;
        IR_CU = 1'b1; ir_rd = 4'd15; in = 32'h555; LOAD = 1'b1;
        tick();
        idle();
        expect_val(32'h100); check_val("pc_loadpc_priority", PCout);

        // Port A to PC beats port B and increment; the collision also flags.
        ir_rd = 4'd15; in = 32'h400; LOAD = 1'b1;
        wb_addr = 4'd15; wb_data = 32'h500; wb_we = 1'b1; PC_INC = 1'b1;
        tick();
        idle();
        expect_val(32'h400); check_val("pc_porta_priority", PCout);
        expect_val(32'h1); check_val("pc_conflict", {31'b0, wr_conflict});

        // Port B to PC beats increment.
        wb_addr = 4'd15; wb_data = 32'h300; wb_we = 1'b1; PC_INC = 1'b1;
        tick();
        idle();
        expect_val(32'h300); check_val("pc_portb_priority", PCout);

        // Wrap: 0xFFFFFFFC + 4 -> 0.
        LOADPC = 1'b1; Pcin = 32'hFFFF_FFFC;
        tick();
        idle();
        PC_INC = 1'b1;
        tick();
        idle();
        expect_val(32'h0); check_val("pc_wrap", PCout);

        // Write-then-read timing on R7 and on the PC index.
        IR_CU = 1'b1; ir_rd = 4'd7; in = 32'h99; LOAD = 1'b1; ir_rm = 4'd7;
        ir_rn = 4'd15; PC_INC = 1'b1;
        #1;
`ifdef RF_BYPASS_EN
        expect_val(32'h99); check_val("rm_before_edge", Rm);
        expect_val(32'h4); check_val("pc_read_before_edge", Rn);
`else
        expect_val(32'h0); check_val("rm_before_edge", Rm);
        expect_val(32'h0); check_val("pc_read_before_edge", Rn);
`endif
        expect_val(32'h0); check_val("pcout_registered", PCout);
        tick();
        idle();
        expect_val(32'h99); check_val("rm_after_edge", Rm);
        expect_val(32'h4); check_val("pcout_after_edge", PCout);

        // Every expected value was consumed.
        checks++;
        assert (exp_q.size() === 0) else begin
            errors++;
            $error("FAIL queue_drained: observed=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised successor to the 16x32 CPU register file.
- Configurable width and register count; general registers plus a dedicated PC at the top index.
- Two write ports (ALU result and base-register writeback), three read ports, PC load/increment logic and a write-collision flag.
- Sits between decode/control unit and the ALU/shifter datapath.

Parameters:
- WIDTH, 32, data width of every register and port.
- ADDR_W, 4, select field width; NREGS = 2**ADDR_W.
- PC_STEP, 4, amount added to PC on PC_INC.
- RESET_PC, 0, PC value after reset.

Ports:
- Clk  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-low reset.
- IR_CU  input  1  1 = use ir_* selects, 0 = use cu_* selects.
- ir_rn, ir_rm, ir_rs, ir_rd  input  ADDR_W each  select fields from instruction register.
- cu_rn, cu_rm, cu_rs, cu_rd  input  ADDR_W each  select fields from control unit.
- in  input  WIDTH  write port A data, written to selected Rd.
- LOAD  input  1  write enable, port A.
- wb_addr  input  ADDR_W  write port B address (never muxed by IR_CU).
- wb_data  input  WIDTH  write port B data.
- wb_we  input  1  write enable, port B.
- Pcin  input  WIDTH  PC load value.
- LOADPC  input  1  load PC from Pcin.
- PC_INC  input  1  PC += PC_STEP.
- Rn, Rm, Rs  output  WIDTH  read data for selected Rn/Rm/Rs.
- PCout  output  WIDTH  current PC.
- wr_conflict  output  1  registered; port A and port B hit the same register last edge.

Behaviour:
- Index PC_IDX = NREGS-1 is the PC; indices 0..NREGS-2 are general registers.
- Select mux: sel_x = IR_CU ? ir_x : cu_x, for x in rn, rm, rs, rd. Purely combinational.
- Reads: combinational, zero latency. Reading PC_IDX returns the PC register. Values are pre-edge unless RF_BYPASS_EN.
- General register write, posedge Clk:
  - Port A (LOAD, sel_rd) has priority over port B (wb_we, wb_addr) on the same index.
  - Different indices: both written in the same cycle.
- PC update, posedge Clk, priority highest first:
  - LOADPC -> Pcin
  - LOAD with sel_rd == PC_IDX -> in
  - wb_we with wb_addr == PC_IDX -> wb_data
  - PC_INC -> PC + PC_STEP, modulo 2**WIDTH, wraps silently
  - otherwise hold.
- wr_conflict: set at an edge where LOAD && wb_we && sel_rd == wb_addr. Cleared at the next edge without that condition. Pulses for exactly one cycle per collision, independent of LOADPC.
- Reset (RESET == 0): takes effect immediately, regardless of Clk.
  - All general registers -> 0, PC -> RESET_PC, wr_conflict -> 0.
  - Writes are ignored while asserted, including an edge coincident with assertion.
  - After deassertion, the first rising edge performs normal writes.
- Disabled inputs (LOAD = 0, wb_we = 0) leave registers untouched even if data inputs are X/Z.
- No internal state other than the register array, PC and wr_conflict. No FSM beyond PC priority logic.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined:
  - Each read port forwards same-cycle write data when its select matches an enabled write, using the same priority as the register update.
  - A PC_IDX read forwards the next PC value (LOADPC/port A/port B/PC_INC result).
  - PCout itself stays registered.
- Undefined: reads always return stored (pre-edge) values. Write-then-read needs one cycle.

Test Plan:
1. Reset and hold: RESET = 0 mid-cycle after writing R3 = 0x55 -> R3 reads 0 and PCout = RESET_PC immediately (async). With RESET low and LOAD = 1, in = 7 on the next edge -> still 0.
2. Chained increment via R0..R2:
   - Edge 1: IR_CU = 1, ir_rd = 0, in = 1, LOAD -> R0 = 1.
   - Edge 2: feed Rn (ir_rn = 0) + 1 into in, ir_rd = 1 -> R1 = 2.
   - Edge 3: repeat with ir_rn = 1, ir_rd = 2 -> R2 = 3.
   - Reads Rn/Rm/Rs with selects 0/1/2 return 1/2/3.
3. IR_CU mux: ir_rn = 1, cu_rn = 2, R1 = 0xA, R2 = 0xB -> Rn = 0xA with IR_CU = 1, Rn = 0xB with IR_CU = 0. Repeat for the rd path: a write lands in ir_rd vs cu_rd accordingly.
4. Dual write and conflict:
   - LOAD rd = 4, in = 0x11 and wb_we wb_addr = 5, wb_data = 0x22 -> R4 = 0x11, R5 = 0x22, wr_conflict = 0.
   - Same index 6 -> R6 = port A value, wr_conflict = 1 for exactly one cycle.
5. PC priority and wrap:
   - PC_INC from 0 for 3 edges -> PCout = 12.
   - LOADPC with Pcin = 0x100 plus PC_INC plus LOAD rd = 15 -> PCout = 0x100.
   - Pcin = 0xFFFFFFFC then PC_INC -> PCout = 0.
6. Bypass:
   - With RF_BYPASS_EN: LOAD rd = 7, in = 0x99, ir_rm = 7 -> Rm = 0x99 before the edge.
   - Without RF_BYPASS_EN: Rm shows the old value until after the edge.
